piso_reg: RTL and testbench
===========================

PISO_REG -- requirements
Module: piso_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width in bits, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load, input, 1 bit: parallel-word valid.
REQ-006 SHALL have port data_in, input, WIDTH bits: parallel word to serialize.
REQ-007 SHALL have port ready, output, 1 bit: the block can accept a word in this cycle.
REQ-008 SHALL have port serial_out, output, 1 bit: current serial bit.
REQ-009 SHALL have port serial_valid, output, 1 bit: serial_out carries a frame bit.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse coincident with the last bit of a frame.

Function
REQ-011 SHALL implement two states: IDLE and SHIFT, plus PARITY when PISO_PARITY_EN is defined.
REQ-012 SHALL accept a word on a rising edge where load=1 and ready=1; data_in is captured into an internal shift register on that edge.
REQ-013 SHALL drive the first frame bit on serial_out with serial_valid=1 in the cycle immediately after acceptance (latency 1 cycle).
REQ-014 SHALL present one bit per clock for WIDTH consecutive cycles, with no gaps, in the order set by MSB_FIRST.
REQ-015 SHALL use a bit counter of ceil(log2(WIDTH)) bits, counting 0..WIDTH-1 with no wrap beyond WIDTH-1.
REQ-016 SHALL assert ready combinationally when the state is IDLE, or during the last frame-bit cycle; ready SHALL be 0 in all other cycles.
REQ-017 SHALL ignore load=1 while ready=0; no capture occurs and the frame in flight is unaffected.
REQ-018 SHALL start the next frame back-to-back when a word is accepted in the last-bit cycle: the first bit of the new frame follows the last bit of the old frame with zero idle cycles, and done still pulses.
REQ-019 SHALL ignore changes on data_in after acceptance.
REQ-020 SHALL assert done=1 only in the last-bit cycle of each frame.
REQ-021 SHALL return to IDLE after the last bit when no new word is accepted, and SHALL hold serial_out=0 and serial_valid=0 while in IDLE.

Reset
REQ-022 SHALL, while reset=0, immediately force state=IDLE, the shift register to 0, the counter to 0, serial_out=0, serial_valid=0 and done=0; ready SHALL read 1.
REQ-023 SHALL abort a frame in progress when reset is asserted mid-frame; no further bits of that frame are emitted after reset is released.
REQ-024 SHALL require a load edge after reset release before any serial output is produced.

Configuration
REQ-025 SHALL, when macro PISO_PARITY_EN is defined, append one even-parity bit (XOR of all WIDTH data bits) after the data bits, in state PARITY; the frame is WIDTH+1 cycles long and done and the back-to-back ready window move to the parity cycle.
REQ-026 SHALL, when PISO_PARITY_EN is not defined, have frames of exactly WIDTH cycles and contain no parity logic.

Verification (WIDTH=8, MSB_FIRST=1 unless stated)
REQ-027 SHALL verify reset: hold reset=0 for 2 cycles with load=1 and data_in=8'hFF -> serial_valid=0, serial_out=0, done=0, ready=1.
REQ-028 SHALL verify a single frame: load 8'hAA for one cycle -> serial_out is 1,0,1,0,1,0,1,0 in cycles 1..8, done high in cycle 8 only, then serial_valid=0.
REQ-029 SHALL verify LSB-first ordering: with MSB_FIRST=0, load 8'h0F -> serial_out is 1,1,1,1,0,0,0,0.
REQ-030 SHALL verify back-to-back frames: load 8'hAA, then hold load=1 with 8'h55 from cycle 2 -> 8'h55 is accepted only in cycle 8, and 16 contiguous valid bits 10101010 01010101 are emitted with two done pulses.
REQ-031 SHALL verify mid-frame reset: load 8'hFF, assert reset=0 in cycle 4, release it -> output stays idle until the next load, with no residual bits.
REQ-032 SHALL verify parity: with PISO_PARITY_EN defined, load 8'h07 -> bits 0,0,0,0,0,1,1,1 followed by parity 1 in cycle 9, with done in cycle 9.

Source files
------------

// File: rtl/piso_reg.sv
// Parallel-in serial-out register with load/ready handshake and back-to-back framing.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of each frame.
module piso_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int unsigned     CntW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt    = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] PreLastCnt = CntW'(WIDTH - 2);

  typedef enum logic [1:0] {
    StIdle,
`ifdef PISO_PARITY_EN
    StParity,
`endif
    StShift
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_shifted;
  logic [CntW-1:0]  cnt_q;
  logic             valid_q;
  logic             done_q;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  // done_q marks the final cycle of a frame, which is also the back-to-back load window.
  assign ready        = (state_q == StIdle) || done_q;
  assign accept       = load && ready;
  assign serial_out   = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
  assign serial_valid = valid_q;
  assign done         = done_q;

  always_comb begin
    sr_shifted = sr_q;
    if (MSB_FIRST != 0) begin
      sr_shifted = {sr_q[WIDTH-2:0], 1'b0};
    end else begin
      sr_shifted = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= StShift;
      sr_q    <= data_in;
      cnt_q   <= '0;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= ^data_in;
`endif
    end else begin
      unique case (state_q)
        StShift: begin
          if (cnt_q == LastCnt) begin
`ifdef PISO_PARITY_EN
            // Replicated so the parity bit appears regardless of shift direction.
            state_q <= StParity;
            sr_q    <= {WIDTH{par_q}};
            done_q  <= 1'b1;
`else
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
            sr_q  <= sr_shifted;
`ifdef PISO_PARITY_EN
            done_q <= 1'b0;
`else
            done_q <= (cnt_q == PreLastCnt);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        StParity: begin
          state_q <= StIdle;
          sr_q    <= '0;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
`endif
        default: begin
          state_q <= StIdle;
          sr_q    <= '0;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_reg.sv
// Directed bench for piso_reg: an MSB-first and an LSB-first instance, 8-bit words.
// Frame length follows PISO_PARITY_EN so the same bench covers both builds.
module tb_piso_reg;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       load_a, load_b;
  logic [7:0] data_a, data_b;
  logic       ready_a, out_a, valid_a, done_a;
  logic       ready_b, out_b, valid_b, done_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  piso_reg #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .load(load_a), .data_in(data_a),
    .ready(ready_a), .serial_out(out_a), .serial_valid(valid_a), .done(done_a)
  );

  piso_reg #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .load(load_b), .data_in(data_b),
    .ready(ready_b), .serial_out(out_b), .serial_valid(valid_b), .done(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    check({tag, " valid"}, 32'(sel ? valid_b : valid_a), 32'd0);
    check({tag, " out"},   32'(sel ? out_b : out_a),     32'd0);
    check({tag, " done"},  32'(sel ? done_b : done_a),   32'd0);
    check({tag, " ready"}, 32'(sel ? ready_b : ready_a), 32'd1);
  endtask

  // e[i] is the expected bit in frame cycle i+1 (bit 8 is the parity bit).
  task automatic frame(input bit sel, input logic [7:0] word, input logic [0:8] e,
                       input string tag);
    if (sel) begin load_b = 1'b1; data_b = word; end
    else     begin load_a = 1'b1; data_a = word; end
    tick();
    load_a = 1'b0; load_b = 1'b0;
    data_a = ~word; data_b = ~word;
    for (int i = 0; i < FL; i++) begin
      check($sformatf("%s bit%0d", tag, i), 32'(sel ? out_b : out_a), 32'(e[i]));
      check($sformatf("%s valid%0d", tag, i), 32'(sel ? valid_b : valid_a), 32'd1);
      check($sformatf("%s done%0d", tag, i), 32'(sel ? done_b : done_a), 32'(i == FL - 1));
      check($sformatf("%s ready%0d", tag, i), 32'(sel ? ready_b : ready_a), 32'(i == FL - 1));
      tick();
    end
    check_idle(sel, {tag, " after"});
  endtask

  initial begin
    logic [0:8] e1;
    logic [0:8] e2;
    reset  = 1'b0;
    load_a = 1'b1; data_a = 8'hFF;
    load_b = 1'b1; data_b = 8'hFF;
    tick();
    tick();
    check_idle(1'b0, "reset_a");
    check_idle(1'b1, "reset_b");

    load_a = 1'b0; load_b = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    check_idle(1'b0, "post_reset_a");

    frame(1'b0, 8'hAA, 9'b101010100, "aa_msb");
    frame(1'b1, 8'h0F, 9'b111100000, "0f_lsb");
    frame(1'b0, 8'h07, 9'b000001111, "07_msb");

    // Back-to-back: AA accepted, then load held high with 55 from cycle 2.
    e1 = 9'b101010100;
    e2 = 9'b010101010;
    load_a = 1'b1; data_a = 8'hAA;
    tick();
    load_a = 1'b0;
    for (int i = 0; i < 2 * FL; i++) begin
      check($sformatf("b2b bit%0d", i), 32'(out_a), 32'(i < FL ? e1[i] : e2[i - FL]));
      check($sformatf("b2b valid%0d", i), 32'(valid_a), 32'd1);
      check($sformatf("b2b done%0d", i), 32'(done_a), 32'(i == FL - 1 || i == 2 * FL - 1));
      load_a = (i + 1 >= 2 && i + 1 <= FL);
      data_a = 8'h55;
      tick();
    end
    load_a = 1'b0;
    check_idle(1'b0, "b2b after");

    // Mid-frame reset: three bits out, then reset in cycle 4.
    load_a = 1'b1; data_a = 8'hFF;
    tick();
    load_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid bit%0d", i), 32'(out_a), 32'd1);
      tick();
    end
    reset = 1'b0;
    #1;
    check_idle(1'b0, "mid in_reset");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("mid idle valid%0d", i), 32'(valid_a), 32'd0);
      check($sformatf("mid idle out%0d", i), 32'(out_a), 32'd0);
    end

    frame(1'b0, 8'hAA, 9'b101010100, "after_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
